sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 154 +++++++++++++++
 tb/tb_sram_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported SRAM controller.
// It holds one transaction at a time. Each transaction issues one trigger
// pulse, waits out the fixed read or write latency, then acks the winning
// port for one cycle.
module sram_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int READ_LAT   = 2,
  parameter int WRITE_LAT  = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iReqA,
  input  logic                  iReqB,
  input  logic                  iWeA,
  input  logic                  iWeB,
  input  logic [ADDR_WIDTH-1:0] iAddrA,
  input  logic [ADDR_WIDTH-1:0] iAddrB,
  input  logic [DATA_WIDTH-1:0] iWrDataA,
  input  logic [DATA_WIDTH-1:0] iWrDataB,
  output logic                  oAckA,
  output logic                  oAckB,
  output logic [DATA_WIDTH-1:0] oRdDataA,
  output logic [DATA_WIDTH-1:0] oRdDataB,
  output logic                  oMemTrigger,
  output logic                  oMemWrite,
  output logic [ADDR_WIDTH-1:0] oMemAddr,
  output logic [DATA_WIDTH-1:0] oMemWrData,
  input  logic [DATA_WIDTH-1:0] iMemRdData,
  output logic                  oBusy
);

  // The counter has to hold the longer latency minus one. It is never
  // narrower than one bit.
  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  last_b_q, last_b_d;   // 1: port B was served last
  logic                  win_b_q, win_b_d;     // 1: current transaction belongs to B
  logic                  ack_a_q, ack_a_d;
  logic                  ack_b_q, ack_b_d;
  logic                  trig_q, trig_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] rd_a_q, rd_a_d;
  logic [DATA_WIDTH-1:0] rd_b_q, rd_b_d;
  logic                  grant_b;

  // B wins when it is the only requester, or on a tie when A was served last.
  always_comb begin
    grant_b = iReqB && (!iReqA || !last_b_q);
  end

  // Next-state and next-output logic. All outputs are decoded one cycle
  // early so that they come straight from flops.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_b_d    = last_b_q;
    win_b_d     = win_b_q;
    ack_a_d     = 1'b0;
    ack_b_d     = 1'b0;
    trig_d      = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_a_d      = rd_a_q;
    rd_b_d      = rd_b_q;
    case (state_q)
      IDLE: begin
        if (iReqA || iReqB) begin
          win_b_d     = grant_b;
          mem_we_d    = grant_b ? iWeB     : iWeA;
          mem_addr_d  = grant_b ? iAddrB   : iAddrA;
          mem_wdata_d = grant_b ? iWrDataB : iWrDataA;
          trig_d      = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = mem_we_q ? WR_LOAD : RD_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = DONE;
          if (!mem_we_q) begin
            if (win_b_q) rd_b_d = iMemRdData;
            else         rd_a_d = iMemRdData;
          end
          if (win_b_q) ack_b_d = 1'b1;
          else         ack_a_d = 1'b1;
        end
      end
      DONE: begin
        last_b_d = win_b_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register. Reset is asynchronous: every flop clears as soon as
  // Reset goes low, whatever the current state.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_b_q    <= 1'b1;
      win_b_q     <= 1'b0;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      trig_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_a_q      <= '0;
      rd_b_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_b_q    <= last_b_d;
      win_b_q     <= win_b_d;
      ack_a_q     <= ack_a_d;
      ack_b_q     <= ack_b_d;
      trig_q      <= trig_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_a_q      <= rd_a_d;
      rd_b_q      <= rd_b_d;
    end
  end

  assign oAckA       = ack_a_q;
  assign oAckB       = ack_b_q;
  assign oRdDataA    = rd_a_q;
  assign oRdDataB    = rd_b_q;
  assign oMemTrigger = trig_q;
  assign oMemWrite   = mem_we_q;
  assign oMemAddr    = mem_addr_q;
  assign oMemWrData  = mem_wdata_q;
  assign oBusy       = (state_q != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed testbench for sram_arbiter with its default parameters
// (16-bit data, 8-bit address, read latency 2, write latency 4).
module tb_sram_arbiter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        iReqA = 1'b0, iReqB = 1'b0;
  logic        iWeA = 1'b0, iWeB = 1'b0;
  logic [7:0]  iAddrA = '0, iAddrB = '0;
  logic [15:0] iWrDataA = '0, iWrDataB = '0;
  logic        oAckA, oAckB;
  logic [15:0] oRdDataA, oRdDataB;
  logic        oMemTrigger, oMemWrite;
  logic [7:0]  oMemAddr;
  logic [15:0] oMemWrData;
  logic [15:0] iMemRdData = '0;
  logic        oBusy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_a, exp_b;
  logic        want_b;

  sram_arbiter dut (
    .Clock(Clock), .Reset(Reset),
    .iReqA(iReqA), .iReqB(iReqB),
    .iWeA(iWeA), .iWeB(iWeB),
    .iAddrA(iAddrA), .iAddrB(iAddrB),
    .iWrDataA(iWrDataA), .iWrDataB(iWrDataB),
    .oAckA(oAckA), .oAckB(oAckB),
    .oRdDataA(oRdDataA), .oRdDataB(oRdDataB),
    .oMemTrigger(oMemTrigger), .oMemWrite(oMemWrite),
    .oMemAddr(oMemAddr), .oMemWrData(oMemWrData),
    .iMemRdData(iMemRdData), .oBusy(oBusy)
  );

  always #5 Clock = ~Clock;

  // Count one comparison and report it if the values differ.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    // Reset state: apply a real falling edge on Reset.
    #2 Reset = 1'b0;
    #1;
    check_val("rst_busy", oBusy, 0);
    check_val("rst_addr", oMemAddr, 0);
    check_val("rst_trig", oMemTrigger, 0);
    check_val("rst_rda", oRdDataA, 0);
    tick(2);
    check_val("rst_ack", {oAckA, oAckB}, 0);
    Reset = 1'b1;

    // Read on port A. The accepting edge is E0, and the ack follows on E3.
    iReqA = 1; iWeA = 0; iAddrA = 8'h10; iMemRdData = 16'hDEAD;
    tick(1);
    check_val("rdA_trig", oMemTrigger, 1);
    check_val("rdA_addr", oMemAddr, 8'h10);
    check_val("rdA_we", oMemWrite, 0);
    check_val("rdA_busy", oBusy, 1);
    tick(1);
    check_val("rdA_trig_off", oMemTrigger, 0);
    check_val("rdA_e1_ack", oAckA, 0);
    tick(1);
    check_val("rdA_e2_ack", oAckA, 0);
    check_val("rdA_e2_data", oRdDataA, 0);
    iMemRdData = 16'hBEEF;
    tick(1);
    check_val("rdA_ack", oAckA, 1);
    check_val("rdA_ackB", oAckB, 0);
    check_val("rdA_data", oRdDataA, 16'hBEEF);
    $display("txn read A addr=10 data=%0h", oRdDataA);
    iReqA = 0;
    tick(1);
    check_val("rdA_idle_busy", oBusy, 0);
    check_val("rdA_idle_ack", oAckA, 0);

    // Write on port B. The ack follows on E5.
    iReqB = 1; iWeB = 1; iAddrB = 8'h22; iWrDataB = 16'h1234; iMemRdData = 16'h5555;
    tick(1);
    check_val("wrB_trig", oMemTrigger, 1);
    check_val("wrB_we", oMemWrite, 1);
    check_val("wrB_addr", oMemAddr, 8'h22);
    check_val("wrB_wdata", oMemWrData, 16'h1234);
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      check_val("wrB_hold_we", oMemWrite, 1);
      check_val("wrB_hold_wdata", oMemWrData, 16'h1234);
      check_val("wrB_early_ack", oAckB, 0);
      check_val("wrB_trig_off", oMemTrigger, 0);
    end
    tick(1);
    check_val("wrB_ack", oAckB, 1);
    check_val("wrB_ackA", oAckA, 0);
    check_val("wrB_rdb_unchanged", oRdDataB, 0);
    check_val("wrB_rda_unchanged", oRdDataA, 16'hBEEF);
    $display("txn write B addr=22 data=1234");
    iReqB = 0;
    tick(1);
    check_val("wrB_idle_busy", oBusy, 0);

    // Tie with both ports held high. B was served last, so the grants run A, B, A, B.
    exp_a = 16'hBEEF; exp_b = 16'h0000;
    iReqA = 1; iWeA = 0; iAddrA = 8'h31;
    iReqB = 1; iWeB = 0; iAddrB = 8'h42;
    for (int k = 0; k < 4; k++) begin
      want_b = k[0];
      tick(1);
      check_val("tie_addr", oMemAddr, want_b ? 8'h42 : 8'h31);
      check_val("tie_trig", oMemTrigger, 1);
      iMemRdData = 16'hA000 + 16'(k);
      tick(3);
      check_val("tie_ackA", oAckA, !want_b);
      check_val("tie_ackB", oAckB, want_b);
      if (want_b) exp_b = 16'hA000 + 16'(k);
      else        exp_a = 16'hA000 + 16'(k);
      check_val("tie_rda", oRdDataA, exp_a);
      check_val("tie_rdb", oRdDataB, exp_b);
      $display("txn tie grant %0d to port %s data=%0h", k, want_b ? "B" : "A", iMemRdData);
      if (k == 3) begin
        iReqA = 0; iReqB = 0;
      end
      tick(1);
      check_val("tie_idle_busy", oBusy, 0);
    end

    // Inputs change during a write on A. The latched values must hold until DONE.
    iReqA = 1; iWeA = 1; iAddrA = 8'h55; iWrDataA = 16'hCAFE;
    tick(1);
    check_val("mid_addr0", oMemAddr, 8'h55);
    check_val("mid_we0", oMemWrite, 1);
    iAddrA = 8'hFF; iWrDataA = 16'h0000; iWeA = 0;
    tick(2);
    check_val("mid_addr_wait", oMemAddr, 8'h55);
    check_val("mid_wdata_wait", oMemWrData, 16'hCAFE);
    check_val("mid_we_wait", oMemWrite, 1);
    tick(3);
    check_val("mid_ack", oAckA, 1);
    check_val("mid_addr_done", oMemAddr, 8'h55);
    check_val("mid_we_done", oMemWrite, 1);
    check_val("mid_rda_unchanged", oRdDataA, exp_a);
    $display("txn write A addr=55 data=CAFE (inputs changed mid-op)");
    iReqA = 0;
    tick(1);

    // The request on A is dropped during ISSUE. The transaction still completes.
    iReqA = 1; iWeA = 0; iAddrA = 8'h60; iMemRdData = 16'h7777;
    tick(1);
    check_val("wd_trig", oMemTrigger, 1);
    iReqA = 0;
    tick(2);
    check_val("wd_e2_ack", oAckA, 0);
    tick(1);
    check_val("wd_ack", oAckA, 1);
    check_val("wd_data", oRdDataA, 16'h7777);
    $display("txn read A addr=60 data=%0h (early withdraw)", oRdDataA);
    tick(1);
    check_val("wd_idle_busy", oBusy, 0);

    // Reset is asserted while a read on B is in WAIT.
    iReqB = 1; iWeB = 0; iAddrB = 8'h70;
    tick(1);
    check_val("rw_addr", oMemAddr, 8'h70);
    tick(1);
    check_val("rw_busy_wait", oBusy, 1);
    Reset = 0; iReqB = 0;
    #1;
    check_val("rw_busy", oBusy, 0);
    check_val("rw_addr0", oMemAddr, 0);
    check_val("rw_rda0", oRdDataA, 0);
    check_val("rw_trig0", oMemTrigger, 0);
    tick(3);
    check_val("rw_no_ack", {oAckA, oAckB}, 0);
    $display("txn read B addr=70 aborted by reset");
    Reset = 1;

    // After reset the pointer is back at B, so a tie is granted to A.
    iReqA = 1; iWeA = 0; iAddrA = 8'h81;
    iReqB = 1; iWeB = 0; iAddrB = 8'h82;
    iMemRdData = 16'h1357;
    tick(1);
    check_val("fr_addr", oMemAddr, 8'h81);
    check_val("fr_trig", oMemTrigger, 1);
    tick(3);
    check_val("fr_ackA", oAckA, 1);
    check_val("fr_ackB", oAckB, 0);
    check_val("fr_rda", oRdDataA, 16'h1357);
    check_val("fr_rdb", oRdDataB, 0);
    $display("txn read A addr=81 data=%0h (first after reset)", oRdDataA);
    iReqA = 0; iReqB = 0;
    tick(1);
    check_val("fr_idle_busy", oBusy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
